crtc_timing: RTL and testbench

//   Parametrised 6845-style CRT timing generator; successor to video_gen. Divides pixel_clk to a

---
 rtl/crtc_pkg.sv | 28 ++
 rtl/crtc_sync_pulse.sv | 38 +++
 rtl/crtc_timing.sv | 261 ++++++++++++++++++++++++++
 tb/tb_crtc_timing.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/crtc_pkg.sv
// Shared widths, cursor mode encodings and sync-width helper for the CRT timing generator.
package crtc_pkg;

  localparam int H_W_DEF         = 8;
  localparam int V_W_DEF         = 7;
  localparam int RA_W_DEF        = 5;
  localparam int MA_W_DEF        = 14;
  localparam int CHAR_PIXELS_DEF = 8;
  localparam int SYNC_WIDTH_ZERO = 16;

  typedef enum logic [1:0] {
    CUR_STEADY  = 2'b00,
    CUR_OFF     = 2'b01,
    CUR_BLINK16 = 2'b10,
    CUR_BLINK32 = 2'b11
  } cursor_mode_e;

  typedef enum logic {
    V_ROWS   = 1'b0,
    V_ADJUST = 1'b1
  } v_phase_e;

  // A programmed width of zero means the longest pulse rather than no pulse.
  function automatic logic [4:0] sync_len(input logic [3:0] width);
    return (width == 4'd0) ? 5'(SYNC_WIDTH_ZERO) : {1'b0, width};
  endfunction

endpackage

// File: rtl/crtc_sync_pulse.sv
// Sync pulse stretcher: starts on trigger, stays high for the programmed number of steps.
module crtc_sync_pulse
  import crtc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       trigger,
  input  logic [3:0] width,
  output logic       active
);

  logic [4:0] rem_q, rem_d;

  // rem_q counts the units still owed after the current one; a trigger seen while
  // the pulse is already running is ignored.
  always_comb begin
    rem_d = rem_q;
    if (step) begin
      if (rem_q != 5'd0) begin
        rem_d = rem_q - 5'd1;
      end else if (trigger) begin
        rem_d = sync_len(width) - 5'd1;
      end
    end
  end

  assign active = (rem_q != 5'd0) || trigger;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/crtc_timing.sv
// 6845-style CRT timing generator: character clock, h/v sync and windows, ma/ra and cursor.
// state    | meaning
// V_ROWS   | scanning character rows 0..v_char_total, ra counts within the row
// V_ADJUST | extra scanlines after the last row, ra counts 0..v_adjust-1
module crtc_timing
  import crtc_pkg::*;
#(
  parameter int H_W         = H_W_DEF,
  parameter int V_W         = V_W_DEF,
  parameter int RA_W        = RA_W_DEF,
  parameter int MA_W        = MA_W_DEF,
  parameter int CHAR_PIXELS = CHAR_PIXELS_DEF
) (
  input  logic            pixel_clk,
  input  logic            reset_n,
  input  logic [H_W-1:0]  h_char_total,
  input  logic [H_W-1:0]  h_char_displayed,
  input  logic [H_W-1:0]  h_sync_pos,
  input  logic [3:0]      h_sync_width,
  input  logic [RA_W-1:0] v_char_height,
  input  logic [V_W-1:0]  v_char_total,
  input  logic [V_W-1:0]  v_char_displayed,
  input  logic [V_W-1:0]  v_sync_pos,
  input  logic [3:0]      v_sync_width,
  input  logic [RA_W-1:0] v_adjust,
  input  logic [MA_W-1:0] start_addr,
  input  logic [MA_W-1:0] cursor_addr,
  input  logic [RA_W-1:0] cursor_start,
  input  logic [RA_W-1:0] cursor_end,
  input  logic [1:0]      cursor_mode,
  output logic            char_ce,
  output logic            h_sync,
  output logic            h_active,
  output logic            v_sync,
  output logic            v_active,
  output logic            display_en,
  output logic [MA_W-1:0] ma,
  output logic [RA_W-1:0] ra,
  output logic            cursor,
  output logic            frame_start
);

  localparam int DIV_W = (CHAR_PIXELS > 1) ? $clog2(CHAR_PIXELS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHAR_PIXELS - 1);

  typedef struct packed {
    logic [H_W-1:0]  h_total;
    logic [H_W-1:0]  h_disp;
    logic [H_W-1:0]  h_pos;
    logic [3:0]      h_width;
    logic [RA_W-1:0] v_height;
    logic [V_W-1:0]  v_total;
    logic [V_W-1:0]  v_disp;
    logic [V_W-1:0]  v_pos;
    logic [3:0]      v_width;
    logic [RA_W-1:0] v_adj;
  } cfg_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic             char_ce_q, char_ce_d;
  logic             cfg_loaded_q, cfg_loaded_d;
  cfg_t             cfg_q, cfg_d, cfg_in, cfg;
  logic [H_W-1:0]   h_char_q, h_char_d;
  logic [RA_W-1:0]  ra_cnt_q, ra_cnt_d;
  logic [V_W-1:0]   row_q, row_d;
  v_phase_e         vphase_q, vphase_d;
  logic [MA_W-1:0]  row_base_q, row_base_d;
  logic [MA_W-1:0]  ma_cnt_q, ma_cnt_d;
  logic [4:0]       frame_cnt_q, frame_cnt_d;

  logic             h_sync_q, h_sync_d, h_active_q, h_active_d;
  logic             v_sync_q, v_sync_d, v_active_q, v_active_d;
  logic             display_en_q, display_en_d, cursor_q, cursor_d;
  logic             frame_start_q, frame_start_d;
  logic [MA_W-1:0]  ma_q, ma_d;
  logic [RA_W-1:0]  ra_q, ra_d;

  logic             line_end, frame_end, h_trig, v_trig, hs_on, vs_on;
  logic             h_act, v_act, cur_en;
  logic [MA_W-1:0]  ma_cur, row_base_cur;

  always_comb begin
    cfg_in.h_total  = h_char_total;
    cfg_in.h_disp   = h_char_displayed;
    cfg_in.h_pos    = h_sync_pos;
    cfg_in.h_width  = h_sync_width;
    cfg_in.v_height = v_char_height;
    cfg_in.v_total  = v_char_total;
    cfg_in.v_disp   = v_char_displayed;
    cfg_in.v_pos    = v_sync_pos;
    cfg_in.v_width  = v_sync_width;
    cfg_in.v_adj    = v_adjust;
  end

  // Until the first character after reset has been taken, the live inputs stand in
  // for the shadow copy so the very first frame already runs on real settings.
  assign cfg          = cfg_loaded_q ? cfg_q : cfg_in;
  assign ma_cur       = cfg_loaded_q ? ma_cnt_q : start_addr;
  assign row_base_cur = cfg_loaded_q ? row_base_q : start_addr;

  assign line_end  = (h_char_q == cfg.h_total);
  assign frame_end = line_end &&
                     (((vphase_q == V_ROWS) && (ra_cnt_q == cfg.v_height) &&
                       (row_q == cfg.v_total) && (cfg.v_adj == '0)) ||
                      ((vphase_q == V_ADJUST) && (ra_cnt_q == cfg.v_adj - 1'b1)));

  assign h_trig = (h_char_q == cfg.h_pos);
  assign v_trig = (vphase_q == V_ROWS) && (row_q == cfg.v_pos) && (ra_cnt_q == '0);
  assign h_act  = (h_char_q < cfg.h_disp);
  assign v_act  = (vphase_q == V_ROWS) && (row_q < cfg.v_disp);

  crtc_sync_pulse u_h_sync (
    .clk     (pixel_clk),
    .rst_n   (reset_n),
    .step    (char_ce_q),
    .trigger (h_trig),
    .width   (cfg.h_width),
    .active  (hs_on)
  );

  crtc_sync_pulse u_v_sync (
    .clk     (pixel_clk),
    .rst_n   (reset_n),
    .step    (char_ce_q && line_end),
    .trigger (v_trig),
    .width   (cfg.v_width),
    .active  (vs_on)
  );

  always_comb begin
    case (cursor_mode)
      CUR_STEADY:  cur_en = 1'b1;
      CUR_OFF:     cur_en = 1'b0;
      CUR_BLINK16: cur_en = ~frame_cnt_q[3];
      default:     cur_en = ~frame_cnt_q[4];
    endcase
  end

  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    char_ce_d     = (div_d == DIV_LAST);
    cfg_loaded_d  = cfg_loaded_q | char_ce_q;
    cfg_d         = cfg_q;
    h_char_d      = h_char_q;
    ra_cnt_d      = ra_cnt_q;
    row_d         = row_q;
    vphase_d      = vphase_q;
    row_base_d    = row_base_q;
    ma_cnt_d      = ma_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    h_sync_d      = h_sync_q;
    h_active_d    = h_active_q;
    v_sync_d      = v_sync_q;
    v_active_d    = v_active_q;
    display_en_d  = display_en_q;
    cursor_d      = cursor_q;
    frame_start_d = frame_start_q;
    ma_d          = ma_q;
    ra_d          = ra_q;
    if (char_ce_q) begin
      if (frame_end || !cfg_loaded_q) begin
        cfg_d = cfg_in;
      end
      h_char_d   = line_end ? '0 : h_char_q + 1'b1;
      row_base_d = row_base_cur;
      if (frame_end) begin
        ra_cnt_d    = '0;
        row_d       = '0;
        vphase_d    = V_ROWS;
        frame_cnt_d = frame_cnt_q + 1'b1;
        row_base_d  = start_addr;
        ma_cnt_d    = start_addr;
      end else if (line_end) begin
        ma_cnt_d = row_base_cur;
        if ((vphase_q == V_ADJUST) || (ra_cnt_q != cfg.v_height)) begin
          ra_cnt_d = ra_cnt_q + 1'b1;
        end else begin
          ra_cnt_d   = '0;
          row_base_d = row_base_cur + MA_W'(cfg.h_disp);
          ma_cnt_d   = row_base_cur + MA_W'(cfg.h_disp);
          if (row_q == cfg.v_total) begin
            vphase_d = V_ADJUST;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end else begin
        ma_cnt_d = ma_cur + 1'b1;
      end
      h_sync_d      = hs_on;
      h_active_d    = h_act;
      v_sync_d      = vs_on;
      v_active_d    = v_act;
      display_en_d  = h_act && v_act;
      cursor_d      = h_act && v_act && (ma_cur == cursor_addr) &&
                      (cursor_start <= ra_cnt_q) && (ra_cnt_q <= cursor_end) && cur_en;
      frame_start_d = (h_char_q == '0) && (row_q == '0) && (ra_cnt_q == '0) &&
                      (vphase_q == V_ROWS);
      ma_d          = ma_cur;
      ra_d          = ra_cnt_q;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      char_ce_q     <= 1'b0;
      cfg_loaded_q  <= 1'b0;
      cfg_q         <= '0;
      h_char_q      <= '0;
      ra_cnt_q      <= '0;
      row_q         <= '0;
      vphase_q      <= V_ROWS;
      row_base_q    <= '0;
      ma_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      h_sync_q      <= 1'b0;
      h_active_q    <= 1'b0;
      v_sync_q      <= 1'b0;
      v_active_q    <= 1'b0;
      display_en_q  <= 1'b0;
      cursor_q      <= 1'b0;
      frame_start_q <= 1'b0;
      ma_q          <= '0;
      ra_q          <= '0;
    end else begin
      div_q         <= div_d;
      char_ce_q     <= char_ce_d;
      cfg_loaded_q  <= cfg_loaded_d;
      cfg_q         <= cfg_d;
      h_char_q      <= h_char_d;
      ra_cnt_q      <= ra_cnt_d;
      row_q         <= row_d;
      vphase_q      <= vphase_d;
      row_base_q    <= row_base_d;
      ma_cnt_q      <= ma_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      h_sync_q      <= h_sync_d;
      h_active_q    <= h_active_d;
      v_sync_q      <= v_sync_d;
      v_active_q    <= v_active_d;
      display_en_q  <= display_en_d;
      cursor_q      <= cursor_d;
      frame_start_q <= frame_start_d;
      ma_q          <= ma_d;
      ra_q          <= ra_d;
    end
  end

  assign char_ce     = char_ce_q;
  assign h_sync      = h_sync_q;
  assign h_active    = h_active_q;
  assign v_sync      = v_sync_q;
  assign v_active    = v_active_q;
  assign display_en  = display_en_q;
  assign ma          = ma_q;
  assign ra          = ra_q;
  assign cursor      = cursor_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_crtc_timing.sv
// Bench for crtc_timing: frame-by-frame scoreboard on a one-pixel-per-char instance,
// plus reset/divider behaviour on an eight-pixel-per-char instance.
module tb_crtc_timing;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic [7:0]  h_char_total, h_char_displayed, h_sync_pos;
  logic [3:0]  h_sync_width, v_sync_width;
  logic [4:0]  v_char_height, v_adjust, cursor_start, cursor_end;
  logic [6:0]  v_char_total, v_char_displayed, v_sync_pos;
  logic [13:0] start_addr, cursor_addr;
  logic [1:0]  cursor_mode;

  logic        ce1, hs1, ha1, vs1, va1, de1, cur1, fs1;
  logic [13:0] ma1;
  logic [4:0]  ra1;
  logic        ce8, hs8, ha8, vs8, va8, de8, cur8, fs8;
  logic [13:0] ma8;
  logic [4:0]  ra8;

  typedef struct packed {
    logic       fs, ha, hs, va, vs, de, cur, ce;
    logic [4:0] ra;
    logic [13:0] ma;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  crtc_timing #(.CHAR_PIXELS(1)) dut1 (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .h_char_total(h_char_total), .h_char_displayed(h_char_displayed),
    .h_sync_pos(h_sync_pos), .h_sync_width(h_sync_width),
    .v_char_height(v_char_height), .v_char_total(v_char_total),
    .v_char_displayed(v_char_displayed), .v_sync_pos(v_sync_pos),
    .v_sync_width(v_sync_width), .v_adjust(v_adjust),
    .start_addr(start_addr), .cursor_addr(cursor_addr),
    .cursor_start(cursor_start), .cursor_end(cursor_end), .cursor_mode(cursor_mode),
    .char_ce(ce1), .h_sync(hs1), .h_active(ha1), .v_sync(vs1), .v_active(va1),
    .display_en(de1), .ma(ma1), .ra(ra1), .cursor(cur1), .frame_start(fs1)
  );

  crtc_timing #(.CHAR_PIXELS(8)) dut8 (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .h_char_total(h_char_total), .h_char_displayed(h_char_displayed),
    .h_sync_pos(h_sync_pos), .h_sync_width(h_sync_width),
    .v_char_height(v_char_height), .v_char_total(v_char_total),
    .v_char_displayed(v_char_displayed), .v_sync_pos(v_sync_pos),
    .v_sync_width(v_sync_width), .v_adjust(v_adjust),
    .start_addr(start_addr), .cursor_addr(cursor_addr),
    .cursor_start(cursor_start), .cursor_end(cursor_end), .cursor_mode(cursor_mode),
    .char_ce(ce8), .h_sync(hs8), .h_active(ha8), .v_sync(vs8), .v_active(va8),
    .display_en(de8), .ma(ma8), .ra(ra8), .cursor(cur8), .frame_start(fs8)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for position p of frame n, derived from the frame geometry:
  // 7 rows of 8 scanlines then 4 adjust scanlines, each line htot+1 chars.
  function automatic vec_t model(input int p, input int htot, input int mode, input int n);
    vec_t v;
    int   len, col, line, row, rl, addr;
    logic en;
    len  = htot + 1;
    col  = p % len;
    line = p / len;
    if (line < 56) begin
      row = line / 8;
      rl  = line % 8;
    end else begin
      row = 6;
      rl  = line - 56;
    end
    case (mode)
      0:       en = 1'b1;
      1:       en = 1'b0;
      2:       en = ~n[3];
      default: en = ~n[4];
    endcase
    addr  = 'h100 + row * 3 + col;
    v     = '0;
    v.fs  = (p == 0);
    v.ha  = (col < 3);
    v.hs  = (col == 4) || (col == 5);
    v.va  = (line < 16);
    v.vs  = (line == 24);
    v.de  = v.ha && v.va;
    v.ce  = 1'b1;
    v.ra  = 5'(rl);
    v.cur = v.de && (addr == 'h101) && (rl >= 6) && (rl <= 7) && en;
    if (v.de) v.ma = 14'(addr);
    return v;
  endfunction

  task automatic run_frame(input int n, input int htot, input int mode,
                           input int chg_p, input int chg_val, input bit first);
    vec_t e, a;
    int   len;
    len = (htot + 1) * 60;
    for (int p = 0; p < len; p++) exp_q.push_back(model(p, htot, mode, n));
    for (int p = 0; p < len; p++) begin
      if (!(first && p == 0)) @(negedge pixel_clk);
      if (p == 0) cursor_mode = 2'(mode);
      if (p == chg_p) h_char_total = 8'(chg_val);
      e = exp_q.pop_front();
      a = {fs1, ha1, hs1, va1, vs1, de1, cur1, ce1, ra1, (e.de ? ma1 : 14'd0)};
      chk_val($sformatf("frame%0d_p%0d", n, p), 32'(a), 32'(e));
    end
  endtask

  initial begin
    bit found;
    int first_edge;
    reset_n          = 1'b0;
    h_char_total     = 8'd7;
    h_char_displayed = 8'd3;
    h_sync_pos       = 8'd4;
    h_sync_width     = 4'd2;
    v_char_height    = 5'd7;
    v_char_total     = 7'd6;
    v_char_displayed = 7'd2;
    v_sync_pos       = 7'd3;
    v_sync_width     = 4'd1;
    v_adjust         = 5'd4;
    start_addr       = 14'h100;
    cursor_addr      = 14'h101;
    cursor_start     = 5'd6;
    cursor_end       = 5'd7;
    cursor_mode      = 2'b00;

    #12;
    chk_val("reset_d1", 32'({ce1, hs1, ha1, vs1, va1, de1, cur1, fs1, ra1, ma1}), 32'd0);
    chk_val("reset_d8", 32'({ce8, hs8, ha8, vs8, va8, de8, cur8, fs8, ra8, ma8}), 32'd0);
    repeat (2) @(negedge pixel_clk);
    reset_n = 1'b1;

    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge pixel_clk);
      if (fs1) begin
        found = 1'b1;
        break;
      end
    end
    chk_val("sync_frame_start", 32'(found), 32'd1);

    if (found) begin
      run_frame(0, 7, 0, -1, 0, 1'b1);
      run_frame(1, 7, 0, -1, 0, 1'b0);
      for (int n = 2; n < 18; n++) run_frame(n, 7, 2, -1, 0, 1'b0);
      run_frame(18, 7, 1, -1, 0, 1'b0);
      run_frame(19, 7, 0, 100, 9, 1'b0);
      run_frame(20, 9, 0, -1, 0, 1'b0);
      run_frame(21, 9, 0, -1, 0, 1'b0);
    end

    @(posedge pixel_clk);
    #3 reset_n = 1'b0;
    #1;
    chk_val("midrun_reset_d8", 32'({ce8, hs8, ha8, vs8, va8, de8, cur8, fs8, ra8, ma8}), 32'd0);
    chk_val("midrun_reset_d1", 32'({ce1, hs1, ha1, vs1, va1, de1, cur1, fs1, ra1, ma1}), 32'd0);
    repeat (3) @(negedge pixel_clk);
    reset_n = 1'b1;

    // first_edge is the rising edge that sees char_ce high, i.e. the first char-rate update.
    first_edge = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge pixel_clk);
      #1;
      if (ce8) begin
        first_edge = k + 1;
        break;
      end
    end
    chk_val("ce8_first_edge", 32'(first_edge), 32'd8);
    @(posedge pixel_clk);
    #1;
    chk_val("ce8_pulse_low", 32'(ce8), 32'd0);
    chk_val("fs8_after_first_char", 32'(fs8), 32'd1);
    repeat (7) @(posedge pixel_clk);
    #1;
    chk_val("ce8_period", 32'(ce8), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
